// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the clocked I2C slave and its companions.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } i2c_slv_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and flags scl edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;

  // Chains reset to the idle (pulled-up) bus level so reset release never looks like START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave_reg_controller.sv
// Oversampling I2C slave with an auto-incrementing register pointer and an external register port.
module i2c_slave_reg_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h2A,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  output logic             reg_wr_en,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  output logic [PTR_W-1:0] reg_rd_addr,
  input  logic [7:0]       reg_rd_data,
  output logic             busy
);

  localparam logic [PTR_W-1:0] PtrMax = PTR_W'(NUM_REGS - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_slv_state_t   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_drive_en, drive_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      sda_drive_en <= 1'b0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      sda_drive_en <= drive_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign rx_byte = {shift_q[6:0], sda_s};
  assign ptr_inc = (ptr_q == PtrMax) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    drive_d   = sda_drive_en;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = '0;
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWdata: begin
          // cnt counts sampled bits; the byte is acted on at the fall after the 8th rise.
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (state_q == StWdata && cnt_q == 4'd7) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_inc;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                drive_d = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = StWaitStop;
              end
            end else if (state_q == StPtr) begin
              if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
                ptr_d   = shift_q[PTR_W-1:0];
                state_d = StPtrAck;
                drive_d = 1'b1;
              end else begin
                state_d = StWaitStop;
              end
            end else begin
              state_d = StWdataAck;
              drive_d = 1'b1;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (shift_q[0] == I2C_RW_WRITE) begin
              state_d = StPtr;
              drive_d = 1'b0;
            end else begin
              state_d = StRdata;
              shift_d = reg_rd_data;
              drive_d = ~reg_rd_data[7];
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            state_d = StWdata;
            cnt_d   = '0;
            drive_d = 1'b0;
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = StRdataAck;
              cnt_d   = '0;
              drive_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              drive_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          // cnt==1 marks a master ACK seen; the next byte loads on the following fall.
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (sda_s == I2C_NACK) state_d = StWaitStop;
            else                   cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = StRdata;
            cnt_d   = '0;
            shift_d = reg_rd_data;
            drive_d = ~reg_rd_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign sda         = sda_drive_en ? I2C_ACK : 1'bz;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_addr = ptr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_reg_controller.sv
// Randomised bus-master bench for i2c_slave_reg_controller against a transaction-level register model.
module tb_i2c_slave_reg_controller;
  import i2c_pkg::*;

  localparam int unsigned NUM_REGS = 4;
  localparam logic [6:0]  ADDR     = 7'h2A;
  localparam int          H        = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       o_low = 1'b0;
  wire        sda;
  logic       reg_wr_en, busy;
  logic [1:0] reg_wr_addr, reg_rd_addr;
  logic [7:0] reg_wr_data, reg_rd_data;
  logic [7:0] regfile [NUM_REGS];

  assign sda = (m_low | o_low) ? 1'b0 : 1'bz;
  pullup (sda);
  assign reg_rd_data = regfile[reg_rd_addr];

  always #5 clk = ~clk;

  i2c_slave_reg_controller #(
    .SLAVE_ADDR  (ADDR),
    .NUM_REGS    (NUM_REGS),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl),
    .sda         (sda),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  // Register storage behind the DUT port, plus logs of strobes, DUT sda drive and busy cycles.
  int         wr_cnt = 0;
  int         drv_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] wr_a_log [256];
  logic [7:0] wr_d_log [256];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regfile[i] <= 8'h00;
    end else if (reg_wr_en) begin
      regfile[reg_wr_addr]    <= reg_wr_data;
      wr_a_log[wr_cnt % 256]  <= {6'b0, reg_wr_addr};
      wr_d_log[wr_cnt % 256]  <= reg_wr_data;
      wr_cnt                  <= wr_cnt + 1;
    end
    if (sda === 1'b0 && !m_low && !o_low) drv_cnt <= drv_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int         n_vec = 0;
  int         n_err = 0;
  int         ptr_m = 0;
  logic [7:0] regs_m [NUM_REGS];
  int         exp_a [$];
  int         exp_d [$];
  int         wr_base = 0;
  logic [7:0] tx_data [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(2); m_low = 1'b0; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    m_low = 1'b1; wait_clk(H);
    scl = 1'b0; wait_clk(H);
  endtask

  task automatic bus_stop();
    wait_clk(2); m_low = 1'b1; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    m_low = 1'b0; wait_clk(H);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2); m_low = ~b; wait_clk(H - 2);
    scl = 1'b1; wait_clk(H);
    scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(2); m_low = 1'b0; wait_clk(H - 2);
    scl = 1'b1; wait_clk(H / 2);
    b = sda; wait_clk(H / 2);
    scl = 1'b0;
  endtask

  // other=1 lets the foreign slave pull the ACK slot low.
  task automatic write_byte(input logic [7:0] d, input logic other, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    o_low = other;
    recv_bit(ack);
    o_low = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic addr_phase(input logic rw);
    logic ack;
    bus_start();
    write_byte({ADDR, rw}, 1'b0, ack);
    check_eq("addr_ack", {31'b0, ack}, {31'b0, I2C_ACK});
    check_eq("busy_after_ack", {31'b0, busy}, 32'd1);
  endtask

  task automatic write_part(input int p, input int n);
    logic ack;
    addr_phase(I2C_RW_WRITE);
    write_byte(8'(p), 1'b0, ack);
    if (p < NUM_REGS) begin
      check_eq("ptr_ack", {31'b0, ack}, 32'd0);
      ptr_m = p;
      for (int i = 0; i < n; i++) begin
        write_byte(tx_data[i], 1'b0, ack);
        check_eq("data_ack", {31'b0, ack}, 32'd0);
        exp_a.push_back(ptr_m);
        exp_d.push_back(int'(tx_data[i]));
        regs_m[ptr_m] = tx_data[i];
        ptr_m = (ptr_m + 1) % NUM_REGS;
      end
    end else begin
      check_eq("ptr_nack", {31'b0, ack}, 32'd1);
      for (int i = 0; i < n; i++) begin
        write_byte(tx_data[i], 1'b0, ack);
        check_eq("data_after_nack", {31'b0, ack}, 32'd1);
      end
    end
  endtask

  task automatic read_part(input int n);
    logic [7:0] d;
    addr_phase(I2C_RW_READ);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1));
      check_eq("rd_data", {24'b0, d}, {24'b0, regs_m[ptr_m]});
      ptr_m = (ptr_m + 1) % NUM_REGS;
    end
    wait_clk(H);
    check_eq("rd_release", {31'b0, sda}, 32'd1);
  endtask

  task automatic finish_txn();
    bus_stop();
    wait_clk(4);
    check_eq("busy_after_stop", {31'b0, busy}, 32'd0);
    check_eq("wr_count", wr_cnt - wr_base, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      check_eq("wr_addr", {24'b0, wr_a_log[(wr_base + i) % 256]}, exp_a[i]);
      check_eq("wr_data", {24'b0, wr_d_log[(wr_base + i) % 256]}, exp_d[i]);
    end
    exp_a.delete();
    exp_d.delete();
    wr_base = wr_cnt;
  endtask

  task automatic foreign_txn(input logic [6:0] a, input int n);
    logic ack;
    int   d0, b0;
    d0 = drv_cnt;
    b0 = busy_cnt;
    bus_start();
    write_byte({a, 1'b0}, 1'b1, ack);
    check_eq("foreign_addr_ack", {31'b0, ack}, 32'd0);
    for (int i = 0; i < n; i++) begin
      write_byte(8'($urandom), 1'b1, ack);
      check_eq("foreign_data_ack", {31'b0, ack}, 32'd0);
    end
    finish_txn();
    check_eq("foreign_no_drive", drv_cnt - d0, 32'd0);
    check_eq("foreign_no_busy", busy_cnt - b0, 32'd0);
  endtask

  task automatic reset_mid_read();
    logic [7:0] d;
    logic       b;
    tx_data[0] = 8'h00; tx_data[1] = 8'h00;
    write_part(0, 2);
    finish_txn();
    write_part(0, 0);
    read_part_first: begin
      addr_phase(I2C_RW_READ);
      read_byte(d, 1'b0);
      check_eq("rst_rd_byte0", {24'b0, d}, {24'b0, regs_m[ptr_m]});
      ptr_m = (ptr_m + 1) % NUM_REGS;
    end
    for (int i = 0; i < 3; i++) recv_bit(b);
    wait_clk(2); m_low = 1'b0; wait_clk(H - 2);
    scl = 1'b1; wait_clk(H / 2);
    check_eq("rst_bit_driven", {31'b0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_sda_release", {31'b0, sda}, 32'd1);
    check_eq("rst_wr_en", {31'b0, reg_wr_en}, 32'd0);
    check_eq("rst_wr_addr", {30'b0, reg_wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'b0, reg_wr_data}, 32'd0);
    check_eq("rst_rd_addr", {30'b0, reg_rd_addr}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    wait_clk(H / 2);
    scl = 1'b0;
    wait_clk(H);
    rst = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < NUM_REGS; i++) regs_m[i] = 8'h00;
    exp_a.delete();
    exp_d.delete();
    bus_stop();
    wait_clk(4);
    check_eq("rst_no_strobe", wr_cnt - wr_base, 32'd0);
    wr_base = wr_cnt;
  endtask

  initial begin
    int kind, p, n, n2;
    logic [6:0] fa;
    for (int i = 0; i < NUM_REGS; i++) regs_m[i] = 8'h00;
    wait_clk(5);
    check_eq("reset_wr_en", {31'b0, reg_wr_en}, 32'd0);
    check_eq("reset_wr_addr", {30'b0, reg_wr_addr}, 32'd0);
    check_eq("reset_wr_data", {24'b0, reg_wr_data}, 32'd0);
    check_eq("reset_rd_addr", {30'b0, reg_rd_addr}, 32'd0);
    check_eq("reset_busy", {31'b0, busy}, 32'd0);
    check_eq("reset_sda", {31'b0, sda}, 32'd1);
    rst = 1'b0;
    wait_clk(5);

    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    write_part(1, 3);
    finish_txn();
    tx_data[0] = 8'hAA; tx_data[1] = 8'hBB;
    write_part(3, 2);
    finish_txn();
    tx_data[0] = 8'h5C; tx_data[1] = 8'hE1;
    write_part(2, 2);
    finish_txn();
    write_part(2, 0);
    read_part(2);
    finish_txn();
    write_part(7, 1);
    finish_txn();
    read_part(1);
    finish_txn();
    foreign_txn(7'h33, 2);
    reset_mid_read();

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
      case (kind)
        0: begin
          p = $urandom_range(0, 7);
          n = $urandom_range(0, 3);
          write_part(p, n);
          finish_txn();
        end
        1: begin
          read_part($urandom_range(1, 3));
          finish_txn();
        end
        2: begin
          p = $urandom_range(0, NUM_REGS - 1);
          n = $urandom_range(0, 2);
          n2 = $urandom_range(1, 3);
          write_part(p, n);
          read_part(n2);
          finish_txn();
        end
        default: begin
          fa = 7'($urandom);
          if (fa == ADDR) fa = fa ^ 7'h01;
          foreign_txn(fa, $urandom_range(0, 2));
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_slave_reg_controller.md
# i2c_slave_reg_controller

Clocked, oversampling I2C slave with a parametrised 7-bit address and an auto-incrementing register pointer. It supports multi-byte writes and reads, and repeated START. This is the next-generation replacement for the SCL-clocked single-byte slave on the multi-slave bus: the open-drain `sda`/`scl` nets carry a pullup, and it coexists with other slaves. Register storage sits outside the block, behind a simple write-strobe / read-address port.

## Interface
Parameters:
- `SLAVE_ADDR`, default 7'h2A: 7-bit bus address matched after START.
- `NUM_REGS`, default 4: number of addressable byte registers; range 2..256. `PTR_W = $clog2(NUM_REGS)`.
- `SYNC_STAGES`, default 2: synchroniser depth on `scl`/`sda`; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `scl`  in  1  I2C clock. Input only; the block never stretches the clock.
- `sda`  inout  1  I2C data, open-drain. The block drives 0 or releases to Z, never drives 1.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_wr_addr`  out  PTR_W  register index for the write.
- `reg_wr_data`  out  8  write data.
- `reg_rd_addr`  out  PTR_W  current pointer, presented for reads.
- `reg_rd_data`  in  8  register content at `reg_rd_addr`. Must be valid within the same cycle (combinational or previously registered).
- `busy`  out  1  high from an address-matched ACK until STOP, or until return to IDLE.

## Operation
- Bus synchronisation and event detection:
  - `scl` and `sda` pass through `SYNC_STAGES` flops, then one history flop.
  - START: sda 1→0 while scl high. STOP: sda 0→1 while scl high.
  - Data is sampled on a detected scl rise. `sda` drive changes only on a detected scl fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- Global transitions:
  - START from any state → ADDR, bit counter cleared. This covers repeated START.
  - STOP from any state → IDLE, `sda` released.
- ADDR: shift 8 bits, MSB first.
  - `addr[7:1]==SLAVE_ADDR` → ADDR_ACK: drive `sda`=0 for one SCL period.
  - Mismatch → WAIT_STOP, no ACK, `sda` never driven.
- After ADDR_ACK:
  - If R/W=0 → PTR.
  - If R/W=1 → RDATA, with `reg_rd_data` loaded into the shift register on the scl fall that ends ADDR_ACK.
- PTR: receive the pointer byte.
  - Value < NUM_REGS → ACK, pointer loaded, then WDATA.
  - Value ≥ NUM_REGS → NACK (sda released in the ACK slot), pointer unchanged, then WAIT_STOP.
- WDATA: receive 8 bits, then ACK. `reg_wr_en` pulses with `reg_wr_addr`=pointer and `reg_wr_data`=byte. The pointer then increments.
- RDATA:
  - Drive each bit on the scl fall: 0 → pull low, 1 → release.
  - After the 8th bit, release `sda` for the master ACK slot.
  - Master ACK (sda=0 sampled) → pointer increments, next byte loaded on the following scl fall.
  - Master NACK → WAIT_STOP with `sda` released; the pointer still increments.
- Pointer arithmetic: increments modulo NUM_REGS, so NUM_REGS−1 wraps to 0. It persists across transactions and is cleared only by `rst`.
- Reset, asynchronous:
  - State IDLE, pointer 0, shift register 0, `sda` released (Z).
  - `reg_wr_en`=0, `reg_wr_addr`=0, `reg_wr_data`=0, `reg_rd_addr`=0, `busy`=0.
  - Reset mid-transfer abandons the transfer immediately. No partial write strobe is issued.

## Timing
- Event detection latency from pin to internal event: SYNC_STAGES+1 clk cycles.
- Bus timing requirements:
  - SCL high and low phases ≥ SYNC_STAGES+3 clk cycles each.
  - SDA setup before scl rise ≥ 1 clk cycle after synchronisation.
- `reg_wr_en` asserts exactly 1 cycle after the detected scl rise of data bit 0. It is high for one cycle, with addr and data stable on that cycle. `reg_wr_addr`/`reg_wr_data` hold their values until the next write.
- `reg_rd_addr` updates 1 cycle after a pointer change. `reg_rd_data` is sampled on the detected scl fall that starts the byte, so that byte is immune to later changes.
- ACK/data drive on `sda` changes ≤ 1 clk cycle after the detected scl fall. Data is held through the whole scl high phase.
- STOP and START in the same cycle as a scl edge: START/STOP takes priority, and the edge is ignored.

## Structure
- Package `i2c_pkg`: state enum `i2c_slv_state_t`, constants `I2C_ACK=1'b0` and `I2C_NACK=1'b1`, `I2C_RW_WRITE=0` and `I2C_RW_READ=1`.
- Sub-module `i2c_bus_sync`: synchroniser plus edge, START and STOP detector. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`. Shared with the future clocked master.
- The existing bus-assertion checker binds to this block unchanged. Add a slave checker bound on the internal `sda_drive_en`: no drive while scl high, except during START/STOP.

## Test plan
- Write 3 bytes: addr 0x2A W, ptr 0x01, data 0x11/0x22/0x33 → three `reg_wr_en` pulses at addrs 1, 2, 3, each data matched. ACK on all bytes.
- Pointer wrap: ptr 0x03, data 0xAA, 0xBB (NUM_REGS=4) → writes at addr 3, then addr 0.
- Combined write/read with repeated START: W ptr 0x02, Sr, R, regs {2:0x5C, 3:0xE1}, master ACK then NACK → master reads 0x5C, 0xE1. `sda` released after NACK. `busy` falls after STOP.
- Invalid pointer: ptr 0x07 with NUM_REGS=4 → NACK in the pointer ACK slot, no write strobe, pointer unchanged.
- Address mismatch: addr 0x33 on a bus with this block at 0x2A and other slaves → this block never drives `sda` and `busy` stays 0. The other slave completes normally.
- Reset mid-read: assert `rst` during bit 4 of an RDATA byte → `sda` is Z within the same cycle, all outputs read 0, and the next transaction proceeds normally.
